muldiv_unit: RTL and testbench

Parametrised iterative multiply/divide unit implementing the RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) for the pipelined core's execute stage. The execute stage holds the instruction and asserts `start`, then stalls fetch and decode on `busy`. It consumes `result` on the single-cycle `done` pulse. The pipeline cancels an in-flight operation with `abort` on a branch/jump flush. Operation is one bit per cycle: shift-add for multiply, restoring division for divide. Division by zero and signed overflow take a one-cycle fast path.

---
 rtl/muldiv_unit_if.sv | 17 +
 rtl/muldiv_unit.sv | 148 ++++++++++++++
 tb/tb_muldiv_unit.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and the iterative multiply/divide unit.
// The execute stage drives the request side; the unit drives busy/done/result.
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            abort;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (output start, op, a, b, abort, input busy, done, result);
    modport slave  (input start, op, a, b, abort, output busy, done, result);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: one bit per cycle, shift-add multiply and restoring divide
// on operand magnitudes, with sign fix-up at the end and a one-cycle path for div-by-zero/overflow.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_unit_if.slave bus
);
    localparam int            CW       = $clog2(XLEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [2:0]      r_op;
    logic            r_neg;
    logic [XLEN:0]   r_acc;
    logic [XLEN-1:0] r_lo;
    logic [XLEN-1:0] r_opd;
    logic [XLEN-1:0] r_result;
    logic [CW-1:0]   r_cnt;

    logic            w_accept;
    logic            w_a_sgn;
    logic            w_b_sgn;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_abs;
    logic [XLEN-1:0] w_b_abs;
    logic            w_fast;
    logic [XLEN-1:0] w_fast_res;
    logic [XLEN:0]   w_sum;
    logic [XLEN:0]   w_shift;
    logic [XLEN:0]   w_diff;
    logic [XLEN:0]   w_acc_nxt;
    logic [XLEN-1:0] w_lo_nxt;
    logic            w_busy;
    logic            w_done;

    // Division leaves quotient in lo and remainder in acc; multiply leaves the product in {acc, lo}.
    function automatic logic [XLEN-1:0] finalize(input logic [2:0] op, input logic neg,
                                                 input logic [XLEN-1:0] acc, input logic [XLEN-1:0] lo);
        logic [2*XLEN-1:0] prod;
        logic [XLEN-1:0]   val;
        logic [XLEN-1:0]   res;
        prod = {acc, lo};
        if (neg) prod = -prod;
        val = op[1] ? acc : lo;
        if (neg) val = -val;
        if (op[2])             res = val;
        else if (op == 3'b000) res = prod[XLEN-1:0];
        else                   res = prod[2*XLEN-1:XLEN];
        return res;
    endfunction

    assign w_accept = (r_state == IDLE) && bus.start && !bus.abort;

    always_comb begin
        w_a_sgn    = (bus.op == 3'b001) || (bus.op == 3'b010) || (bus.op == 3'b100) || (bus.op == 3'b110);
        w_b_sgn    = (bus.op == 3'b001) || (bus.op == 3'b100) || (bus.op == 3'b110);
        w_a_neg    = w_a_sgn && bus.a[XLEN-1];
        w_b_neg    = w_b_sgn && bus.b[XLEN-1];
        w_a_abs    = w_a_neg ? -bus.a : bus.a;
        w_b_abs    = w_b_neg ? -bus.b : bus.b;
        w_fast     = 1'b0;
        w_fast_res = '0;
        if (bus.op[2]) begin
            if (bus.b == '0) begin
                w_fast     = 1'b1;
                w_fast_res = bus.op[1] ? bus.a : '1;
            end else if (!bus.op[0] && (bus.a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.b == '1)) begin
                w_fast     = 1'b1;
                w_fast_res = bus.op[1] ? '0 : bus.a;
            end
        end
    end

    always_comb begin
        w_sum   = r_acc + (r_lo[0] ? {1'b0, r_opd} : '0);
        w_shift = {r_acc[XLEN-1:0], r_lo[XLEN-1]};
        w_diff  = w_shift - {1'b0, r_opd};
        if (r_op[2]) begin
            // Guard bit of the trial difference set means the divisor did not fit: restore.
            if (!w_diff[XLEN]) begin
                w_acc_nxt = w_diff;
                w_lo_nxt  = {r_lo[XLEN-2:0], 1'b1};
            end else begin
                w_acc_nxt = w_shift;
                w_lo_nxt  = {r_lo[XLEN-2:0], 1'b0};
            end
        end else begin
            w_acc_nxt = {1'b0, w_sum[XLEN:1]};
            w_lo_nxt  = {w_sum[0], r_lo[XLEN-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = w_fast ? DONE : CALC;
            CALC:    if (r_cnt == '0) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (bus.abort) w_state_nxt = IDLE;
    end

    always_comb begin
        w_busy = (r_state != IDLE);
        w_done = (r_state == DONE);
    end

    assign bus.busy   = w_busy;
    assign bus.done   = w_done;
    assign bus.result = r_result;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_op     <= '0;
            r_neg    <= 1'b0;
            r_acc    <= '0;
            r_lo     <= '0;
            r_opd    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_op  <= bus.op;
            r_neg <= (bus.op == 3'b110) ? w_a_neg : (w_a_neg ^ w_b_neg);
            r_acc <= '0;
            r_cnt <= CNT_LAST;
            r_lo  <= bus.op[2] ? w_a_abs : w_b_abs;
            r_opd <= bus.op[2] ? w_b_abs : w_a_abs;
            if (w_fast) r_result <= w_fast_res;
        end else if ((r_state == CALC) && !bus.abort) begin
            r_acc <= w_acc_nxt;
            r_lo  <= w_lo_nxt;
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == '0) r_result <= finalize(r_op, r_neg, w_acc_nxt[XLEN-1:0], w_lo_nxt);
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed RV32M cases, abort/reset/ignore-start behaviour, and
// randomized operations on a 32-bit and an 8-bit instance against an arithmetic reference.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    muldiv_unit_if #(.XLEN(32)) bus32 ();
    muldiv_unit_if #(.XLEN(8))  bus8 ();

    muldiv_unit #(.XLEN(32)) u_dut32 (.clk(clk), .reset(reset), .bus(bus32));
    muldiv_unit #(.XLEN(8))  u_dut8  (.clk(clk), .reset(reset), .bus(bus8));

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] last_exp32;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on sign-extended operands, RISC-V corner rules.
    function automatic logic [31:0] ref_op(input int w, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint unsigned m, ua, ub;
        longint          sa, sb, minv;
        logic [63:0]     p;
        logic [63:0]     r;
        m    = (64'd1 << w) - 64'd1;
        ua   = 64'(a) & m;
        ub   = 64'(b) & m;
        minv = -(longint'(1) << (w - 1));
        sa   = (((ua >> (w - 1)) & 64'd1) != 0) ? longint'(ua) - (longint'(1) << w) : longint'(ua);
        sb   = (((ub >> (w - 1)) & 64'd1) != 0) ? longint'(ub) - (longint'(1) << w) : longint'(ub);
        case (op)
            3'd0: begin p = ua * ub; r = p & m; end
            3'd1: begin p = sa * sb; r = (p >> w) & m; end
            3'd2: begin p = sa * longint'(ub); r = (p >> w) & m; end
            3'd3: begin p = ua * ub; r = (p >> w) & m; end
            3'd4: begin
                if (ub == 0)                     r = m;
                else if (sa == minv && sb == -1) r = ua;
                else                             r = 64'(sa / sb) & m;
            end
            3'd5: r = (ub == 0) ? m : ((ua / ub) & m);
            3'd6: begin
                if (ub == 0)                     r = ua;
                else if (sa == minv && sb == -1) r = 64'd0;
                else                             r = 64'(sa % sb) & m;
            end
            default: r = (ub == 0) ? ua : ((ua % ub) & m);
        endcase
        return r[31:0];
    endfunction

    function automatic int ref_lat(input int w, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] m, minv;
        m    = 32'((64'd1 << w) - 64'd1);
        minv = 32'(64'd1 << (w - 1));
        if (op[2] && ((b & m) == 0)) return 1;
        if ((op == 3'd4 || op == 3'd6) && ((a & m) == minv) && ((b & m) == m)) return 1;
        return w + 1;
    endfunction

    function automatic logic [31:0] pick(input int w);
        logic [31:0] m, v;
        m = 32'((64'd1 << w) - 64'd1);
        case ($urandom_range(0, 6))
            0:       v = 32'd0;
            1:       v = m;
            2:       v = 32'(64'd1 << (w - 1));
            3:       v = 32'($urandom_range(0, 9));
            default: v = $urandom;
        endcase
        return v & m;
    endfunction

    task automatic drive(input int inst, input logic st, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic ab);
        if (inst == 0) begin
            bus32.start = st; bus32.op = op; bus32.a = a; bus32.b = b; bus32.abort = ab;
        end else begin
            bus8.start = st; bus8.op = op; bus8.a = a[7:0]; bus8.b = b[7:0]; bus8.abort = ab;
        end
    endtask

    // Called at a negedge, which becomes cycle 0; returns at the negedge of the done cycle.
    task automatic run_op(input int inst, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat);
        logic busy_ok;
        logic dn;
        res     = '0;
        lat     = -1;
        busy_ok = 1'b1;
        drive(inst, 1'b1, op, a, b, 1'b0);
        for (int c = 1; c <= 40 && lat < 0; c++) begin
            @(negedge clk);
            drive(inst, 1'b0, op, a, b, 1'b0);
            if (!((inst == 0) ? bus32.busy : bus8.busy)) busy_ok = 1'b0;
            dn = (inst == 0) ? bus32.done : bus8.done;
            if (dn) begin
                lat = c;
                res = (inst == 0) ? bus32.result : {24'd0, bus8.result};
            end
        end
        chk("busy_while_active", 64'(busy_ok), 64'd1);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        vec_t        dv[$];
        logic [31:0] res, a, b, exp;
        logic [2:0]  op;
        int          lat;
        logic        seen;

        dv.push_back('{3'd0, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 33});
        dv.push_back('{3'd1, 32'h80000000,   32'h80000000, 32'h40000000, 33});
        dv.push_back('{3'd3, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 33});
        dv.push_back('{3'd2, 32'hFFFFFFFF,   32'd2,        32'hFFFFFFFF, 33});
        dv.push_back('{3'd4, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 33});
        dv.push_back('{3'd6, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 33});
        dv.push_back('{3'd5, 32'hFFFFFFFF,   32'd16,       32'h0FFFFFFF, 33});
        dv.push_back('{3'd7, 32'd100,        32'd7,        32'd2,        33});
        dv.push_back('{3'd4, 32'd5,          32'd0,        32'hFFFFFFFF, 1});
        dv.push_back('{3'd7, 32'd5,          32'd0,        32'd5,        1});
        dv.push_back('{3'd4, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1});
        dv.push_back('{3'd6, 32'h80000000,   32'hFFFFFFFF, 32'd0,        1});

        reset = 1'b0;
        drive(0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        drive(1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_busy",   64'(bus32.busy),   64'd0);
        chk("rst_done",   64'(bus32.done),   64'd0);
        chk("rst_result", 64'(bus32.result), 64'd0);
        chk("rst_busy8",  64'(bus8.busy),    64'd0);

        foreach (dv[i]) begin
            @(negedge clk);
            run_op(0, dv[i].op, dv[i].a, dv[i].b, res, lat);
            chk($sformatf("dir%0d_res", i), 64'(res), 64'(dv[i].exp));
            chk($sformatf("dir%0d_lat", i), 64'(lat), 64'(dv[i].lat));
            last_exp32 = dv[i].exp;
        end

        // Abort in cycle 10 of a DIV.
        @(negedge clk);
        drive(0, 1'b1, 3'd4, 32'd1000, 32'd7, 1'b0);
        seen = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (bus32.done) seen = 1'b1;
            drive(0, 1'b0, 3'd4, 32'd1000, 32'd7, c == 10);
        end
        @(negedge clk);
        chk("abort_no_done",  64'(seen | bus32.done), 64'd0);
        chk("abort_busy",     64'(bus32.busy),        64'd0);
        chk("abort_result",   64'(bus32.result),      64'(last_exp32));
        run_op(0, 3'd4, 32'd1000, 32'd7, res, lat);
        chk("after_abort_res", 64'(res), 64'd142);
        chk("after_abort_lat", 64'(lat), 64'd33);
        last_exp32 = 32'd142;

        // start together with abort is not accepted.
        @(negedge clk);
        drive(0, 1'b1, 3'd0, 32'd3, 32'd4, 1'b1);
        @(negedge clk);
        drive(0, 1'b0, 3'd0, 32'd3, 32'd4, 1'b0);
        chk("start_abort_busy", 64'(bus32.busy), 64'd0);
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus32.done || bus32.busy) seen = 1'b1;
        end
        chk("start_abort_idle", 64'(seen), 64'd0);

        // start and operand changes during CALC are ignored.
        @(negedge clk);
        drive(0, 1'b1, 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        lat = -1;
        res = '0;
        for (int c = 1; c <= 40 && lat < 0; c++) begin
            @(negedge clk);
            if (bus32.done) begin
                lat = c;
                res = bus32.result;
            end else begin
                drive(0, (c >= 3 && c <= 6), 3'd4, $urandom, $urandom, 1'b0);
            end
        end
        drive(0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        chk("ignore_start_res", 64'(res), 64'hFFFFFFFE);
        chk("ignore_start_lat", 64'(lat), 64'd33);
        last_exp32 = 32'hFFFFFFFE;

        for (int i = 0; i < 50; i++) begin
            op  = 3'($urandom_range(0, 7));
            a   = pick(32);
            b   = pick(32);
            exp = ref_op(32, op, a, b);
            @(negedge clk);
            run_op(0, op, a, b, res, lat);
            chk($sformatf("rnd32_res op%0d %h %h", op, a, b), 64'(res), 64'(exp));
            chk("rnd32_lat", 64'(lat), 64'(ref_lat(32, op, a, b)));
            last_exp32 = exp;
        end

        // reset mid-operation in cycle 5 of a MUL.
        @(negedge clk);
        drive(0, 1'b1, 3'd0, 32'd123, 32'd456, 1'b0);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            drive(0, 1'b0, 3'd0, 32'd123, 32'd456, 1'b0);
        end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("midrst_busy",   64'(bus32.busy),   64'd0);
        chk("midrst_done",   64'(bus32.done),   64'd0);
        chk("midrst_result", 64'(bus32.result), 64'd0);
        seen = 1'b0;
        repeat (36) begin
            @(negedge clk);
            if (bus32.done) seen = 1'b1;
        end
        chk("midrst_no_done", 64'(seen), 64'd0);

        @(negedge clk);
        run_op(1, 3'd1, 32'h80, 32'h7F, res, lat);
        chk("x8_mulh_res", 64'(res), 64'hC0);
        chk("x8_mulh_lat", 64'(lat), 64'd9);

        for (int i = 0; i < 40; i++) begin
            op  = 3'($urandom_range(0, 7));
            a   = pick(8);
            b   = pick(8);
            exp = ref_op(8, op, a, b);
            @(negedge clk);
            run_op(1, op, a, b, res, lat);
            chk($sformatf("rnd8_res op%0d %h %h", op, a, b), 64'(res), 64'(exp));
            chk("rnd8_lat", 64'(lat), 64'(ref_lat(8, op, a, b)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
